// File: rtl/wb_grf_pkg.sv
// wb_grf_pkg: shared encodings for the write-back stage and register file.
// Holds the write-back source select codes, load extension codes, the
// hardwired-zero register index and the sign-extension helpers. It is also
// imported by the controller and the W-stage register producers.
package wb_grf_pkg;

  localparam int unsigned GRF_AW   = 5;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  // Write-back source select; codes 5-7 select a zero value.
  typedef enum logic [2:0] {
    WB_SEL_ALU = 3'd0,
    WB_SEL_MEM = 3'd1,
    WB_SEL_RA  = 3'd2,
    WB_SEL_MD  = 3'd3,
    WB_SEL_CP0 = 3'd4
  } wb_sel_e;

  // Load extension type; codes 5-7 behave as a full-word load.
  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ld_type_e;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/wb_grf_if.sv
// wb_grf_if: W-stage bus between the MEM/WB register / D stage and wb_grf.
// master: the pipeline side, drives W-stage values and read indices.
// slave : wb_grf, returns read data, the write-back value and we_eff.
interface wb_grf_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
);
  logic [DW-1:0] pc_w;
  logic [DW-1:0] dr_w;
  logic [DW-1:0] ao_w;
  logic [AW-1:0] a3_w;
  logic [DW-1:0] ra_w;
  logic [DW-1:0] md_w;
  logic [DW-1:0] cp0_w;
  logic          reg_we;
  logic [2:0]    wb_sel;
  logic [2:0]    ld_type;
  logic [AW-1:0] a1;
  logic [AW-1:0] a2;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic [DW-1:0] wd_w;
  logic          we_eff;

  modport master (
    output pc_w, dr_w, ao_w, a3_w, ra_w, md_w, cp0_w, reg_we, wb_sel, ld_type, a1, a2,
    input  rd1, rd2, wd_w, we_eff
  );

  modport slave (
    input  pc_w, dr_w, ao_w, a3_w, ra_w, md_w, cp0_w, reg_we, wb_sel, ld_type, a1, a2,
    output rd1, rd2, wd_w, we_eff
  );
endinterface

// File: rtl/wb_grf_load_ext.sv
// wb_grf_load_ext: byte/halfword selection and extension of a loaded word.
// Ports: dr_w (raw load word), ao_lo (address bits [1:0]), ld_type (extension
// type), ld_ext (extended value). Little-endian; ao_lo[0] is ignored for
// halfwords because misalignment is trapped upstream.
module wb_grf_load_ext
  import wb_grf_pkg::*;
(
  input  logic [31:0] dr_w,
  input  logic [1:0]  ao_lo,
  input  logic [2:0]  ld_type,
  output logic [31:0] ld_ext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and halfword, then extend per load type.
  always_comb begin
    byte_s = 8'h00;
    half_s = ao_lo[1] ? dr_w[31:16] : dr_w[15:0];
    case (ao_lo)
      2'd0:    byte_s = dr_w[7:0];
      2'd1:    byte_s = dr_w[15:8];
      2'd2:    byte_s = dr_w[23:16];
      2'd3:    byte_s = dr_w[31:24];
      default: byte_s = 8'h00;
    endcase
    case (ld_type)
      LD_B:    ld_ext = sext8(byte_s);
      LD_BU:   ld_ext = {24'h000000, byte_s};
      LD_H:    ld_ext = sext16(half_s);
      LD_HU:   ld_ext = {16'h0000, half_s};
      default: ld_ext = dr_w;
    endcase
  end

endmodule

// File: rtl/wb_grf.sv
// wb_grf: write-back stage and 32x32 general register file.
// Ports: clk, reset (synchronous, active high), bus (wb_grf_if.slave) carrying
// the W-stage inputs, the two D-stage read ports rd1/rd2, the write-back
// value wd_w for the forwarding network and the effective write flag we_eff.
// Build option WB_GRF_BYPASS_EN: when defined, a read of the register being
// written this cycle returns wd_w (write-through); otherwise reads return the
// array contents and the hazard unit must forward wd_w itself.
module wb_grf
  import wb_grf_pkg::*;
#(
  parameter int unsigned NREG = 32,
  parameter int unsigned DW   = 32
) (
  input  logic     clk,
  input  logic     reset,
  wb_grf_if.slave  bus
);

  logic [DW-1:0] reg_r [NREG];
  logic [31:0]   ld_ext_s;
  logic [DW-1:0] wd_s;
  logic          we_eff_s;
  logic [DW-1:0] rd1_s;
  logic [DW-1:0] rd2_s;
  logic          trace_unused_s;

  // pc_w is carried for trace only.
  assign trace_unused_s = ^bus.pc_w;

  wb_grf_load_ext u_load_ext (
    .dr_w    (bus.dr_w),
    .ao_lo   (bus.ao_w[1:0]),
    .ld_type (bus.ld_type),
    .ld_ext  (ld_ext_s)
  );

  assign we_eff_s = bus.reg_we && (bus.a3_w != REG_ZERO);

  // Write-back source select.
  always_comb begin
    case (bus.wb_sel)
      WB_SEL_ALU: wd_s = bus.ao_w;
      WB_SEL_MEM: wd_s = ld_ext_s;
      WB_SEL_RA:  wd_s = bus.ra_w;
      WB_SEL_MD:  wd_s = bus.md_w;
      WB_SEL_CP0: wd_s = bus.cp0_w;
      default:    wd_s = {DW{1'b0}};
    endcase
  end

  // Register array: reset clears everything and wins over a pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        reg_r[i] <= {DW{1'b0}};
      end
    end else if (we_eff_s) begin
      reg_r[bus.a3_w] <= wd_s;
    end
  end

  // Read port 1; index 0 is forced to zero independent of array contents.
  always_comb begin
    rd1_s = {DW{1'b0}};
    if (bus.a1 == REG_ZERO) begin
      rd1_s = {DW{1'b0}};
`ifdef WB_GRF_BYPASS_EN
    end else if (we_eff_s && (bus.a1 == bus.a3_w)) begin
      rd1_s = wd_s;
`endif
    end else begin
      rd1_s = reg_r[bus.a1];
    end
  end

  // Read port 2; same rules as port 1.
  always_comb begin
    rd2_s = {DW{1'b0}};
    if (bus.a2 == REG_ZERO) begin
      rd2_s = {DW{1'b0}};
`ifdef WB_GRF_BYPASS_EN
    end else if (we_eff_s && (bus.a2 == bus.a3_w)) begin
      rd2_s = wd_s;
`endif
    end else begin
      rd2_s = reg_r[bus.a2];
    end
  end

  assign bus.rd1    = rd1_s;
  assign bus.rd2    = rd2_s;
  assign bus.wd_w   = wd_s;
  assign bus.we_eff = we_eff_s;

endmodule
